// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-FF synchroniser, start-bit qualification and mid-bit sampling.
// Reports each good byte with a one-cycle done strobe and a bad stop bit with a frame-error strobe.
module uart_rx #(
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 57600
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_rx_done,
    output logic       uart_frame_err,
    output logic       uart_rx_busy
);
    localparam int BPS_CNT = SYS_CLK_FRE / BPS;
    localparam logic [15:0] HALF = 16'(BPS_CNT / 2 - 1);
    localparam logic [15:0] FULL = 16'(BPS_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        fall;

    assign fall           = rx_s3_q & ~rx_s2_q;
    assign uart_data      = data_q;
    assign uart_rx_done   = done_q;
    assign uart_frame_err = err_q;
    assign uart_rx_busy   = state_q != IDLE;

    // Synchroniser presets to idle-high so reset release never looks like a start edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_s1_q   <= uart_rxd;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = state_q == IDLE ? 16'd0 : clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: if (fall) state_d = START;
            START: if (clk_cnt_q == HALF) begin
                state_d   = rx_s2_q ? IDLE : DATA;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            DATA: if (clk_cnt_q == FULL) begin
                shift_d   = {rx_s2_q, shift_q[7:1]};
                clk_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = STOP;
            end
            STOP: if (clk_cnt_q == FULL) begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed
                state_d   = IDLE;
                clk_cnt_d = '0;
                data_d    = rx_s2_q ? shift_q : data_q;
                done_d    = rx_s2_q;
                err_d     = ~rx_s2_q;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into uart_rx and checks strobes, data and latency via a scoreboard.
module tb_uart_rx;
    localparam int BPS_CNT = 16;
    localparam int LAT     = 155;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       done, err, busy;

    typedef struct {
        logic       is_err;
        logic [7:0] d;
        int         t0;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         errs = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;

    uart_rx #(.SYS_CLK_FRE(1_000_000), .BPS(62500)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .uart_rxd(rxd),
        .uart_data(data),
        .uart_rx_done(done),
        .uart_frame_err(err),
        .uart_rx_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        step(BPS_CNT);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int gap);
        exp_t e;
        e.is_err = ~stop;
        e.d      = b;
        e.t0     = cyc;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rxd = 1'b1;
        step(gap);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            check("done_and_err_together", {31'd0, done & err}, 0);
            check("pulse_consecutive", {31'd0, prev_pulse}, 0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, done, err}, 0);
            end else begin
                exp_t e;
                int lat;
                e = q.pop_front();
                lat = cyc - e.t0;
                check("pulse_kind_err", {31'd0, err}, {31'd0, e.is_err});
                if (!e.is_err) last_good = e.d;
                check("uart_data", {24'd0, data}, {24'd0, last_good});
                check("latency_in_window", {31'd0, lat >= LAT - 2 && lat <= LAT + 2}, 1);
            end
        end
        prev_pulse = done | err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        step(5);
        rst = 1'b0;
        step(100);
        check("idle_data", {24'd0, data}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_done", {31'd0, done}, 0);
        check("idle_err", {31'd0, err}, 0);

        send(8'h55, 1'b1, 20);
        send(8'hA3, 1'b1, 0);
        send(8'h0F, 1'b1, 20);

        cnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) rxd = 1'b1;
            step(1);
            if (busy) cnt++;
        end
        check("glitch_busy_bounded", {31'd0, cnt >= 1 && cnt <= 8}, 1);
        check("glitch_busy_clear", {31'd0, busy}, 0);

        send(8'h3C, 1'b1, 10);
        send(8'hF0, 1'b0, 32);
        send(8'h12, 1'b1, 20);

        // Abort 0xFF mid data bit 3 with a one-cycle reset
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rxd = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        last_good = 8'h00;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_data", {24'd0, data}, 0);
        check("rst_done", {31'd0, done}, 0);
        step(8 + 4 * BPS_CNT + 20);
        check("post_rst_busy", {31'd0, busy}, 0);
        send(8'h81, 1'b1, 20);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       s;
            b = 8'($urandom_range(0, 255));
            s = $urandom_range(0, 4) != 0;
            send(b, s, s ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 30)));
        end

        for (int i = 0; i < 400 && q.size() != 0; i++) step(1);
        check("queue_drained", q.size(), 0);
        step(20);
        check("final_busy", {31'd0, busy}, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
